// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// master: the pipeline stage issuing requests; slave: the memory answering them.
interface mem_stage_if #(
  parameter int WIDTH = 32
);
  logic             req;
  logic             we;
  logic [WIDTH-3:0] addr;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             ack;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB of the five-stage pipeline.
// Non-memory instructions pass to WB with one cycle of latency. Loads and
// stores are issued on the dmem req/ack bus; EX is stalled (in_ready low) and
// WB receives bubbles until the access completes.
// Optional feature: define MEM_TIMEOUT_EN to abandon an access that has not
// been acknowledged within TIMEOUT cycles (sticky mem_err, Z_out forced to 0).
//
// Opcode encoding (IR[WIDTH-1:WIDTH-6]):
//   NOP 6'h00  ADD 6'h01  SUB 6'h02
//   LW  6'h10 (word)  LH 6'h11 (half)  LD 6'h12 (byte)
//   SW  6'h14 (word)  SH 6'h15 (half)  SD 6'h16 (byte)
//   HALT 6'h3F
module mem_stage #(
  parameter int                 WIDTH   = 32,
  parameter logic [WIDTH-1:0]   NOP_IR  = 32'h0000_0000,
  parameter int                 TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] IR_in,
  input  logic [WIDTH-3:0] PC_in,
  input  logic [WIDTH-1:0] Z_in,
  input  logic [WIDTH-1:0] B_in,
  mem_stage_if.master      dmem,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-3:0] PC_out,
  output logic [WIDTH-1:0] Z_out,
  output logic             halted,
  output logic             mem_err
);

  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_LH   = 6'h11;
  localparam logic [5:0] OP_LD   = 6'h12;
  localparam logic [5:0] OP_SW   = 6'h14;
  localparam logic [5:0] OP_SH   = 6'h15;
  localparam logic [5:0] OP_SD   = 6'h16;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] ir_out_reg, ir_out_next;
  logic [WIDTH-3:0] pc_out_reg, pc_out_next;
  logic [WIDTH-1:0] z_out_reg, z_out_next;
  logic [WIDTH-1:0] ir_lat_reg, ir_lat_next;
  logic [WIDTH-3:0] pc_lat_reg, pc_lat_next;
  logic [WIDTH-1:0] z_lat_reg, z_lat_next;
  logic             req_reg, req_next;
  logic             we_reg, we_next;
  logic [WIDTH-3:0] addr_reg, addr_next;
  logic [3:0]       be_reg, be_next;
  logic [WIDTH-1:0] wdata_reg, wdata_next;
  logic             halted_reg, halted_next;
  logic             ready_reg, ready_next;
  logic             err_reg, err_next;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

  logic [5:0] op_in;
  logic [5:0] op_lat;
  logic       accept;
  logic       in_is_mem;
  logic       in_is_store;
  logic [3:0] in_be;
  logic [WIDTH-1:0] in_wdata;
  logic [WIDTH-1:0] load_data;

  assign op_in  = IR_in[WIDTH-1 -: 6];
  assign op_lat = ir_lat_reg[WIDTH-1 -: 6];
  assign accept = in_valid & ready_reg;

  // Decode the incoming instruction: memory class, lane enables and store data.
  always_comb begin
    in_is_mem   = 1'b0;
    in_is_store = 1'b0;
    in_be       = 4'b0000;
    in_wdata    = B_in;
    case (op_in)
      OP_LW, OP_SW: begin
        in_is_mem   = 1'b1;
        in_is_store = (op_in == OP_SW);
        in_be       = 4'b1111;
        in_wdata    = B_in;
      end
      OP_LH, OP_SH: begin
        in_is_mem   = 1'b1;
        in_is_store = (op_in == OP_SH);
        in_be       = 4'b0011 << {Z_in[1], 1'b0};
        in_wdata    = {(WIDTH/16){B_in[15:0]}};
      end
      OP_LD, OP_SD: begin
        in_is_mem   = 1'b1;
        in_is_store = (op_in == OP_SD);
        in_be       = 4'b0001 << Z_in[1:0];
        in_wdata    = {(WIDTH/8){B_in[7:0]}};
      end
      default: ;
    endcase
  end

  // Right-justify and zero-extend the addressed part of the read data.
  always_comb begin
    load_data = '0;
    case (op_lat)
      OP_LW:   load_data = dmem.rdata;
      OP_LH:   load_data = {{(WIDTH-16){1'b0}}, 16'(dmem.rdata >> {z_lat_reg[1], 4'b0000})};
      OP_LD:   load_data = {{(WIDTH-8){1'b0}}, 8'(dmem.rdata >> {z_lat_reg[1:0], 3'b000})};
      default: load_data = z_lat_reg;
    endcase
  end

  // Next-state and output logic; WB sees a bubble unless something completes.
  always_comb begin
    state_next  = state_reg;
    ir_out_next = NOP_IR;
    pc_out_next = '0;
    z_out_next  = '0;
    ir_lat_next = ir_lat_reg;
    pc_lat_next = pc_lat_reg;
    z_lat_next  = z_lat_reg;
    req_next    = req_reg;
    we_next     = we_reg;
    addr_next   = addr_reg;
    be_next     = be_reg;
    wdata_next  = wdata_reg;
    halted_next = halted_reg;
    err_next    = err_reg;
`ifdef MEM_TIMEOUT_EN
    cnt_next    = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (in_is_mem) begin
            state_next  = ACCESS;
            ir_lat_next = IR_in;
            pc_lat_next = PC_in;
            z_lat_next  = Z_in;
            req_next    = 1'b1;
            we_next     = in_is_store;
            addr_next   = Z_in[WIDTH-1:2];
            be_next     = in_be;
            wdata_next  = in_wdata;
`ifdef MEM_TIMEOUT_EN
            cnt_next    = '0;
`endif
          end else begin
            ir_out_next = IR_in;
            pc_out_next = PC_in;
            z_out_next  = Z_in;
            if (op_in == OP_HALT) begin
              halted_next = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (dmem.ack) begin
          state_next  = IDLE;
          req_next    = 1'b0;
          we_next     = 1'b0;
          be_next     = 4'b0000;
          ir_out_next = ir_lat_reg;
          pc_out_next = pc_lat_reg;
          z_out_next  = load_data;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          // Give up on the access; the instruction still retires with Z=0.
          state_next  = IDLE;
          req_next    = 1'b0;
          we_next     = 1'b0;
          be_next     = 4'b0000;
          err_next    = 1'b1;
          ir_out_next = ir_lat_reg;
          pc_out_next = pc_lat_reg;
          z_out_next  = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    ready_next = (state_next == IDLE) && !halted_next;
  end

  // State and output registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      ir_out_reg <= NOP_IR;
      pc_out_reg <= '0;
      z_out_reg  <= '0;
      ir_lat_reg <= NOP_IR;
      pc_lat_reg <= '0;
      z_lat_reg  <= '0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      addr_reg   <= '0;
      be_reg     <= 4'b0000;
      wdata_reg  <= '0;
      halted_reg <= 1'b0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      ir_out_reg <= ir_out_next;
      pc_out_reg <= pc_out_next;
      z_out_reg  <= z_out_next;
      ir_lat_reg <= ir_lat_next;
      pc_lat_reg <= pc_lat_next;
      z_lat_reg  <= z_lat_next;
      req_reg    <= req_next;
      we_reg     <= we_next;
      addr_reg   <= addr_next;
      be_reg     <= be_next;
      wdata_reg  <= wdata_next;
      halted_reg <= halted_next;
      ready_reg  <= ready_next;
      err_reg    <= err_next;
`ifdef MEM_TIMEOUT_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  assign in_ready   = ready_reg;
  assign IR_out     = ir_out_reg;
  assign PC_out     = pc_out_reg;
  assign Z_out      = z_out_reg;
  assign halted     = halted_reg;
  assign dmem.req   = req_reg;
  assign dmem.we    = we_reg;
  assign dmem.addr  = addr_reg;
  assign dmem.be    = be_reg;
  assign dmem.wdata = wdata_reg;

`ifdef MEM_TIMEOUT_EN
  assign mem_err = err_reg;
`else
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of single transactions plus
// hand-written sequences for reset, back-to-back, stall and HALT behaviour.
module tb_mem_stage;
  localparam int WIDTH = 32;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h10;
  localparam logic [5:0] OP_LH   = 6'h11;
  localparam logic [5:0] OP_LD   = 6'h12;
  localparam logic [5:0] OP_SW   = 6'h14;
  localparam logic [5:0] OP_SH   = 6'h15;
  localparam logic [5:0] OP_SD   = 6'h16;
  localparam logic [5:0] OP_HALT = 6'h3F;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] IR_in = '0;
  logic [WIDTH-3:0] PC_in = '0;
  logic [WIDTH-1:0] Z_in = '0;
  logic [WIDTH-1:0] B_in = '0;
  logic [WIDTH-1:0] IR_out;
  logic [WIDTH-3:0] PC_out;
  logic [WIDTH-1:0] Z_out;
  logic             halted;
  logic             mem_err;

  mem_stage_if #(.WIDTH(WIDTH)) dmem ();

  mem_stage #(.WIDTH(WIDTH), .NOP_IR(32'h0000_0000), .TIMEOUT(15)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .IR_in    (IR_in),
    .PC_in    (PC_in),
    .Z_in     (Z_in),
    .B_in     (B_in),
    .dmem     (dmem.master),
    .IR_out   (IR_out),
    .PC_out   (PC_out),
    .Z_out    (Z_out),
    .halted   (halted),
    .mem_err  (mem_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] z;
    logic [31:0] b;
    logic [31:0] rdata;
    logic        is_mem;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [29:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_z;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: in_ready stuck at %b", in_ready);
    end
  endtask

  // One transaction: present the instruction, and for memory ops answer
  // the request after 'delay' idle cycles. Returns number of cycles in_ready low.
  task automatic run_op(input vec_t v, input int delay, input logic [29:0] pc, output int low_cycles);
    logic [31:0] ir;
    ir = {v.op, 26'h0000_ABC};
    low_cycles = 0;
    wait_ready();
    IR_in = ir; PC_in = pc; Z_in = v.z; B_in = v.b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (v.is_mem) begin
      chk("req_up", {31'b0, dmem.req}, 32'd1);
      chk("we", {31'b0, dmem.we}, {31'b0, v.exp_we});
      chk("be", {28'b0, dmem.be}, {28'b0, v.exp_be});
      chk("addr", {2'b0, dmem.addr}, {2'b0, v.exp_addr});
      if (v.exp_we) chk("wdata", dmem.wdata, v.exp_wdata);
      chk("bubble_ir", IR_out, 32'h0);
      for (int i = 0; i < delay; i++) begin
        if (in_ready === 1'b0) low_cycles++;
        step();
        chk("req_hold", {31'b0, dmem.req}, 32'd1);
        chk("bubble_wait", IR_out, 32'h0);
      end
      if (in_ready === 1'b0) low_cycles++;
      dmem.ack = 1'b1; dmem.rdata = v.rdata;
      step();
      dmem.ack = 1'b0; dmem.rdata = 32'h0;
      chk("req_down", {31'b0, dmem.req}, 32'd0);
    end
    $display("op=%02h z=%08h -> IR_out=%08h PC_out=%08h Z_out=%08h", v.op, v.z, IR_out, PC_out, Z_out);
    chk("ir_out", IR_out, ir);
    chk("pc_out", {2'b0, PC_out}, {2'b0, pc});
    chk("z_out", Z_out, v.exp_z);
  endtask

  initial begin
    int low;
    vec_t v;
    dmem.ack = 1'b0;
    dmem.rdata = '0;

    //           op      z             b             rdata         mem we  be       addr      wdata         exp_z
    vecs[0] = '{OP_ADD, 32'h0000_0005, 32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,    32'h0,        32'h0000_0005};
    vecs[1] = '{OP_LW,  32'h0000_0100, 32'h0,        32'hDEADBEEF, 1, 0, 4'b1111, 30'h40,   32'h0,        32'hDEADBEEF};
    vecs[2] = '{OP_LD,  32'h0000_0103, 32'h0,        32'h11223344, 1, 0, 4'b1000, 30'h40,   32'h0,        32'h0000_0011};
    vecs[3] = '{OP_SH,  32'h0000_0102, 32'hAAAABEEF, 32'h0,        1, 1, 4'b1100, 30'h40,   32'hBEEFBEEF, 32'h0000_0102};
    vecs[4] = '{OP_LH,  32'h0000_0202, 32'h0,        32'h11223344, 1, 0, 4'b1100, 30'h80,   32'h0,        32'h0000_1122};
    vecs[5] = '{OP_LH,  32'h0000_0200, 32'h0,        32'h11223344, 1, 0, 4'b0011, 30'h80,   32'h0,        32'h0000_3344};
    vecs[6] = '{OP_SD,  32'h0000_0101, 32'h12345678, 32'h0,        1, 1, 4'b0010, 30'h40,   32'h78787878, 32'h0000_0101};
    vecs[7] = '{OP_SW,  32'h0000_0013, 32'hCAFEF00D, 32'h0,        1, 1, 4'b1111, 30'h4,    32'hCAFEF00D, 32'h0000_0013};
    vecs[8] = '{OP_LD,  32'h0000_0101, 32'h0,        32'h11223344, 1, 0, 4'b0010, 30'h40,   32'h0,        32'h0000_0033};
    vecs[9] = '{OP_SUB, 32'h0000_0007, 32'h0,        32'h0,        0, 0, 4'b0000, 30'h0,    32'h0,        32'h0000_0007};

    // Reset state
    #12;
    chk("rst_ir", IR_out, 32'h0);
    chk("rst_z", Z_out, 32'h0);
    chk("rst_req", {31'b0, dmem.req}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Reset mid-access drops req asynchronously
    IR_in = {OP_LW, 26'h0}; Z_in = 32'h100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("midacc_req", {31'b0, dmem.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-access: req=%b IR_out=%08h halted=%b", dmem.req, IR_out, halted);
    chk("async_rst_req", {31'b0, dmem.req}, 32'd0);
    chk("async_rst_ir", IR_out, 32'h0);
    chk("async_rst_halted", {31'b0, halted}, 32'd0);
    #2 rst_n = 1'b1;
    step();

    // Table-driven transactions (memory ops acked in the first req cycle)
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], 0, 30'(i + 1), low);
    end

    // LW with ack after 3 wait cycles: in_ready low for 4 cycles
    v = vecs[1];
    run_op(v, 3, 30'h55, low);
    chk("lw_ready_low", low, 32'd4);
    chk("lw_ready_back", {31'b0, in_ready}, 32'd1);

    // Back-to-back ADD then SUB
    IR_in = {OP_ADD, 26'h1}; Z_in = 32'h5; in_valid = 1'b1;
    step();
    chk("b2b_z0", Z_out, 32'h5);
    chk("b2b_rdy0", {31'b0, in_ready}, 32'd1);
    IR_in = {OP_SUB, 26'h2}; Z_in = 32'h7;
    step();
    in_valid = 1'b0;
    $display("back-to-back: Z_out=%08h in_ready=%b", Z_out, in_ready);
    chk("b2b_z1", Z_out, 32'h7);
    chk("b2b_rdy1", {31'b0, in_ready}, 32'd1);
    step();
    chk("idle_bubble", IR_out, 32'h0);

    // Stray ack with nothing outstanding is ignored
    dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
    step();
    dmem.ack = 1'b0;
    chk("stray_ack_z", Z_out, 32'h0);
    chk("stray_ack_req", {31'b0, dmem.req}, 32'd0);
    chk("stray_ack_rdy", {31'b0, in_ready}, 32'd1);

`ifdef MEM_TIMEOUT_EN
    begin
      int hi = 0;
      IR_in = {OP_LW, 26'h3}; Z_in = 32'h40; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      while (dmem.req === 1'b1 && hi < 100) begin
        hi++;
        step();
      end
      $display("timeout: req high %0d cycles mem_err=%b Z_out=%08h", hi, mem_err, Z_out);
      chk("to_cycles", hi, 32'd15);
      chk("to_err", {31'b0, mem_err}, 32'd1);
      chk("to_z", Z_out, 32'h0);
      chk("to_ir", IR_out, {OP_LW, 26'h3});
    end
`endif

    // HALT, then in_valid held high: never consumed again
    IR_in = {OP_HALT, 26'h0}; PC_in = 30'h99; Z_in = 32'h0; in_valid = 1'b1;
    step();
    chk("halt_ir", IR_out, {OP_HALT, 26'h0});
    chk("halt_flag", {31'b0, halted}, 32'd1);
    chk("halt_rdy", {31'b0, in_ready}, 32'd0);
    IR_in = {OP_ADD, 26'h0}; Z_in = 32'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("halt_hold_rdy", {31'b0, in_ready}, 32'd0);
      chk("halt_hold_flag", {31'b0, halted}, 32'd1);
      chk("halt_hold_ir", IR_out, 32'h0);
    end
    $display("halt: halted=%b in_ready=%b IR_out=%08h", halted, in_ready, IR_out);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
